// File: rtl/mem_io_pkg.sv
// Shared definitions for the CPU-side memory/I-O responder:
// the I/O window map and its address decode helpers.
package mem_io_pkg;

    localparam int BYTE_W = 8;
    typedef logic [BYTE_W-1:0] byte_t;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam logic [31:0] IO_UART = 32'h0003_0000;
    localparam logic [31:0] IO_CLK  = 32'h0003_0004;

    typedef enum logic [2:0] {
        IO_REG_UART,
        IO_REG_CLK0,
        IO_REG_CLK1,
        IO_REG_CLK2,
        IO_REG_CLK3,
        IO_REG_NONE
    } io_reg_e;

    // region is mem_a[17:16]; the top quarter of the 18-bit space is I/O
    function automatic logic io_sel(input logic [1:0] region);
        return region == 2'b11;
    endfunction

    function automatic io_reg_e io_decode(input logic [17:0] offset);
        io_reg_e r;
        case (offset)
            IO_UART[17:0]:        r = IO_REG_UART;
            IO_CLK[17:0]:         r = IO_REG_CLK0;
            IO_CLK[17:0] + 18'd1: r = IO_REG_CLK1;
            IO_CLK[17:0] + 18'd2: r = IO_REG_CLK2;
            IO_CLK[17:0] + 18'd3: r = IO_REG_CLK3;
            default:              r = IO_REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with combinational head read; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module byte_fifo
    import mem_io_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  byte_t                    din,
    output byte_t                    dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    byte_t          mem_reg [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           push_ok;
    logic           pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_FULL);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok && !srst) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: byte RAM below the I/O window, and UART
// FIFOs, cycle counter and program-stop flag inside it.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int FULL_MARGIN = 4,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_done,
    output logic        tx_overflow
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam logic [TX_CW-1:0] TX_THRESH = TX_CW'(TX_DEPTH - FULL_MARGIN);

    byte_t                   ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic                    ram_we;

    logic                    io_hit;
    io_reg_e                 io_reg;
    byte_t                   io_rdata;
    logic                    unused_addr_bits;

    byte_t                   mem_din_reg;
    logic [31:0]             counter_reg;
    logic [31:0]             snapshot_reg;
    logic                    program_done_reg;
    logic                    tx_overflow_reg;
    logic                    io_buffer_full_reg;

    logic                    tx_push;
    logic                    tx_pop;
    byte_t                   tx_push_data;
    logic                    tx_empty;
    logic                    tx_full;
    logic [TX_CW-1:0]        tx_count_unused;
    logic [TX_CW-1:0]        tx_count_next;

    logic                    rx_push;
    logic                    rx_pop;
    byte_t                   rx_dout;
    logic                    rx_empty;
    logic                    rx_full;
    logic [RX_CW-1:0]        rx_count_unused;
    logic [RX_CW-1:0]        rx_count_next_unused;

    assign ram_addr         = mem_a[ADDR_WIDTH-1:0];
    assign io_hit           = io_sel(mem_a[17:16]);
    assign io_reg           = io_decode(mem_a[17:0]);
    assign unused_addr_bits = ^mem_a[31:18];
    assign ram_we           = mem_wr && !io_hit && !rst_in;

    assign tx_push      = mem_wr && io_hit &&
                          ((io_reg == IO_REG_UART && mem_dout != 8'h00) || io_reg == IO_REG_CLK0);
    // a program-stop write emits a 0x00 marker byte on the UART
    assign tx_push_data = (io_reg == IO_REG_CLK0) ? 8'h00 : mem_dout;
    assign tx_pop       = tx_valid && tx_ready;
    assign rx_push      = rx_valid && rx_ready;
    assign rx_pop       = !mem_wr && io_hit && io_reg == IO_REG_UART && !rx_empty;

    assign tx_valid       = !tx_empty;
    assign rx_ready       = !rx_full;
    assign mem_din        = mem_din_reg;
    assign program_done   = program_done_reg;
    assign tx_overflow    = tx_overflow_reg;
    assign io_buffer_full = io_buffer_full_reg;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk        (clk_in),
        .srst       (rst_in),
        .push       (tx_push),
        .pop        (tx_pop),
        .din        (tx_push_data),
        .dout       (tx_data),
        .empty      (tx_empty),
        .full       (tx_full),
        .count      (tx_count_unused),
        .count_next (tx_count_next)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk        (clk_in),
        .srst       (rst_in),
        .push       (rx_push),
        .pop        (rx_pop),
        .din        (rx_data),
        .dout       (rx_dout),
        .empty      (rx_empty),
        .full       (rx_full),
        .count      (rx_count_unused),
        .count_next (rx_count_next_unused)
    );

    always_comb begin
        io_rdata = 8'h00;
        case (io_reg)
            IO_REG_UART: io_rdata = rx_empty ? 8'h00 : rx_dout;
            IO_REG_CLK0: io_rdata = counter_reg[7:0];
            IO_REG_CLK1: io_rdata = snapshot_reg[15:8];
            IO_REG_CLK2: io_rdata = snapshot_reg[23:16];
            IO_REG_CLK3: io_rdata = snapshot_reg[31:24];
            default:     io_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_addr] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din_reg        <= 8'h00;
            counter_reg        <= 32'h0;
            snapshot_reg       <= 32'h0;
            program_done_reg   <= 1'b0;
            tx_overflow_reg    <= 1'b0;
            io_buffer_full_reg <= 1'b0;
        end else begin
            if (rdy_in) begin
                counter_reg <= counter_reg + 32'd1;
            end
            if (!mem_wr) begin
                if (io_hit) begin
                    mem_din_reg <= io_rdata;
                    if (io_reg == IO_REG_CLK0) begin
                        snapshot_reg <= counter_reg;
                    end
                end else begin
                    mem_din_reg <= ram[ram_addr];
                end
            end else if (io_hit && io_reg == IO_REG_CLK0) begin
                program_done_reg <= 1'b1;
            end
            if (tx_push && tx_full && !tx_pop) begin
                tx_overflow_reg <= 1'b1;
            end
            io_buffer_full_reg <= (tx_count_next >= TX_THRESH);
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, UART FIFOs, cycle counter
// snapshot and program-stop flag, each vector checked against constants.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_done;
    logic        tx_overflow;

    int vectors = 0;
    int miscompares = 0;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .program_done   (program_done),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        mem_a = a; mem_dout = d; mem_wr = 1'b1;
        step();
        mem_wr = 1'b0; mem_a = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        mem_a = a; mem_wr = 1'b0;
        step();
        mem_a = 32'h0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; mem_a = 32'h0; mem_dout = 8'h00; mem_wr = 1'b0;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        step(); step();
        rst_in = 1'b0;
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_program_done", program_done, 1'b0);
        check("rst_tx_overflow", tx_overflow, 1'b0);
        check("rst_io_buffer_full", io_buffer_full, 1'b0);

        // RAM write then read, one cycle latency
        bus_write(32'h10, 8'hA5);
        check("ram_write_holds_din", mem_din, 8'h00);
        bus_read(32'h10);
        check("ram_read_a5", mem_din, 8'hA5);

        // TX: nonzero byte pushed, zero byte ignored
        tx_ready = 1'b1;
        bus_write(32'h30000, 8'h48);
        check("tx_beat_valid", tx_valid, 1'b1);
        check("tx_beat_data", tx_data, 8'h48);
        bus_write(32'h30000, 8'h00);
        check("tx_zero_no_beat", tx_valid, 1'b0);
        step();
        check("tx_idle_no_beat", tx_valid, 1'b0);

        // TX fill to near-full, full, then overflow
        tx_ready = 1'b0;
        for (int i = 1; i <= 11; i++) bus_write(32'h30000, 8'(8'h10 + i));
        check("tx_11_not_near_full", io_buffer_full, 1'b0);
        bus_write(32'h30000, 8'h1C);
        check("tx_12_near_full", io_buffer_full, 1'b1);
        for (int i = 13; i <= 16; i++) bus_write(32'h30000, 8'(8'h10 + i));
        check("tx_16_no_overflow", tx_overflow, 1'b0);
        bus_write(32'h30000, 8'h21);
        check("tx_17_overflow", tx_overflow, 1'b1);
        check("tx_full_near_full", io_buffer_full, 1'b1);
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("tx_drain_valid_%0d", i), tx_valid, 1'b1);
            check($sformatf("tx_drain_data_%0d", i), tx_data, 8'(8'h10 + i));
            step();
        end
        check("tx_drained_empty", tx_valid, 1'b0);
        check("tx_drained_not_near_full", io_buffer_full, 1'b0);
        check("tx_overflow_sticky", tx_overflow, 1'b1);

        // RX: two bytes in, three reads out
        rx_valid = 1'b1; rx_data = 8'h31;
        step();
        rx_data = 8'h32;
        step();
        rx_valid = 1'b0;
        bus_read(32'h30000);
        check("rx_read_31", mem_din, 8'h31);
        bus_read(32'h30000);
        check("rx_read_32", mem_din, 8'h32);
        bus_read(32'h30000);
        check("rx_read_empty", mem_din, 8'h00);
        check("rx_ready_after", rx_ready, 1'b1);

        // Cycle counter: 300 counted edges after reset -> 0x12C
        rst_in = 1'b1; rdy_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("rst2_tx_overflow", tx_overflow, 1'b0);
        for (int i = 0; i < 300; i++) step();
        bus_read(32'h30004);
        check("clk_byte0", mem_din, 8'h2C);
        for (int i = 0; i < 300; i++) step();
        bus_read(32'h30005);
        check("clk_byte1_snapshot", mem_din, 8'h01);
        bus_read(32'h30006);
        check("clk_byte2", mem_din, 8'h00);
        bus_read(32'h30007);
        check("clk_byte3", mem_din, 8'h00);
        bus_read(32'h30008);
        check("io_other_reads_zero", mem_din, 8'h00);

        // Program stop, then reset clears state but not RAM
        tx_ready = 1'b0;
        bus_write(32'h30004, 8'h77);
        check("stop_program_done", program_done, 1'b1);
        check("stop_tx_valid", tx_valid, 1'b1);
        check("stop_tx_data", tx_data, 8'h00);
        rst_in = 1'b1; mem_a = 32'h10; mem_dout = 8'h5A; mem_wr = 1'b1;
        step();
        rst_in = 1'b0; mem_wr = 1'b0;
        check("rst3_program_done", program_done, 1'b0);
        check("rst3_tx_empty", tx_valid, 1'b0);
        check("rst3_rx_ready", rx_ready, 1'b1);
        check("rst3_mem_din", mem_din, 8'h00);
        bus_read(32'h10);
        check("ram_survives_reset", mem_din, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
